cyc_arbiter: RTL and testbench
==============================

Name: cyc_arbiter

Overview:
- Shares the cycle control state counter (CYCFSM) between three requesters: CPU, DMA and memory refresh.
- Grants exactly one requester per memory cycle and drives the cycle-type qualifiers SHORT_n, SLOW_n and BRK_n into the FSM.
- Closes the cycle on the FSM's TERM_n and returns a one-cycle DONE pulse to the owner.
- Aborts hung cycles with a watchdog.

Parameters:
- DMA_BURST, 4: maximum consecutive DMA grants while CPU is requesting.
- TMO_CYC, 64: CK cycles in CYCLE without TERM_n before abort.
- TMO_W, 7: width of the watchdog counter; must satisfy 2^TMO_W > TMO_CYC.

Ports:
- CK  in  1  system clock (OSC); all state updates on rising edge.
- MR_n  in  1  master reset, asynchronous, active-low.
- CPUREQ  in  1  CPU cycle request (level).
- CPUSHORT  in  1  CPU requests a short (50/75 ns) cycle; sampled at grant.
- CPUSLOW  in  1  CPU requests a slow cycle; sampled at grant; ignored when CPUSHORT=1.
- CPUBRK  in  1  CPU requests a break cycle; sampled at grant.
- DMAREQ  in  1  DMA cycle request (level).
- REFREQ  in  1  refresh request (level).
- TERM_n  in  1  cycle terminate from CYCFSM, active-low.
- GNT_CPU, GNT_DMA, GNT_REF  out  1 each  one-hot grant; high for the whole cycle.
- SHORT_n, SLOW_n, BRK_n  out  1 each  cycle-type qualifiers to CYCFSM, active-low.
- DONE_CPU, DONE_DMA, DONE_REF  out  1 each  one-CK cycle-complete pulse.
- TMOUT  out  1  one-CK pulse on watchdog abort.

Behaviour:
- Reset (MR_n=0, asynchronous):
  - state=IDLE; all GNT_*, DONE_*, TMOUT = 0.
  - SHORT_n = SLOW_n = BRK_n = 1.
  - dma_cnt = 0; watchdog = 0.
  - Reset asserted mid-cycle aborts immediately; no DONE or TMOUT is issued.
- All outputs are registered.
- States: IDLE, CYCLE, REC.
- IDLE, no requests: outputs stay inactive.
- IDLE, any request sampled at edge N: after edge N the state is CYCLE and the winner's GNT is high, with qualifiers valid in the same cycle (one-edge latency).
- Priority:
  - REFREQ wins first.
  - Otherwise DMA wins over CPU.
  - Exception: if dma_cnt == DMA_BURST and CPUREQ=1, CPU wins over DMA.
- Qualifiers by winner:
  - CPU: SHORT_n = ~CPUSHORT; SLOW_n = ~(CPUSLOW & ~CPUSHORT); BRK_n = ~CPUBRK.
  - DMA: SLOW_n=0, SHORT_n=1, BRK_n=1.
  - REF: SHORT_n=0, SLOW_n=1, BRK_n=1.
- The qualifiers are latched at grant and held constant through CYCLE.
- dma_cnt update on each grant:
  - DMA grant: increment, saturating at DMA_BURST.
  - CPU grant: clear to 0.
  - REF grant: unchanged.
  - IDLE with CPUREQ=0: clear to 0.
- CYCLE:
  - Request deassertion is ignored; the cycle always completes.
  - The watchdog increments every CK.
  - TERM_n sampled 0: next cycle state=REC, the owner's DONE_x = 1, all GNT = 0, qualifiers return to 1, watchdog cleared.
  - Watchdog reaches TMO_CYC-1 with TERM_n still 1: next cycle state=REC, TMOUT=1, no DONE, grants and qualifiers released, watchdog cleared.
  - TERM_n low on the same edge the watchdog expires: TERM_n wins (DONE, not TMOUT).
- REC:
  - Lasts one CK with no grant; DONE/TMOUT fall after it.
  - Next state is IDLE, so back-to-back cycles are spaced by at least REC+IDLE (2 CK).
  - Requests present in REC are not granted until IDLE.
- TERM_n low in IDLE or REC is ignored.
- Invariant: at most one GNT_* and at most one of DONE_*/TMOUT are high at any time.

Test Plan:
- Reset/basic CPU cycle: MR_n pulse, then CPUREQ=1, CPUSHORT=1. Expect GNT_CPU=1 and SHORT_n=0 after 1 edge; hold TERM_n=1 for 3 CK then 0 for 1 CK; expect DONE_CPU high exactly 1 CK, GNT_CPU=0 in REC.
- Priority: REFREQ=DMAREQ=CPUREQ=1 together. Expect grant order REF, then DMA, then CPU (with REFREQ dropped after its DONE); each grant at least 2 CK after the previous DONE.
- Fairness, DMA_BURST=4: DMAREQ and CPUREQ held 1. Expect 4 GNT_DMA cycles then 1 GNT_CPU, repeating.
- Watchdog, TMO_CYC=64: grant DMA, hold TERM_n=1. Expect TMOUT pulse after 64 CK in CYCLE, no DONE_DMA, return to IDLE.
- Coincident TERM_n and expiry: TERM_n=0 on the 64th CYCLE edge. Expect DONE asserted, TMOUT=0.
- Async reset mid-cycle: MR_n=0 while GNT_CPU=1 and BRK_n=0. Expect all outputs to reset values immediately without waiting for CK; no DONE after release.

Source files
------------

// File: rtl/cyc_arbiter.sv
// Arbitrates the shared cycle control FSM between refresh, DMA and CPU requesters,
// latching cycle-type qualifiers at grant and closing each cycle on TERM_n or watchdog expiry.
module cyc_arbiter #(
    parameter int DMA_BURST = 4,
    parameter int TMO_CYC   = 64,
    parameter int TMO_W     = 7
) (
    input  logic       CK,
    input  logic       MR_n,
    input  logic       CPUREQ,
    input  logic       CPUSHORT,
    input  logic       CPUSLOW,
    input  logic       CPUBRK,
    input  logic       DMAREQ,
    input  logic       REFREQ,
    input  logic       TERM_n,
    output logic       GNT_CPU,
    output logic       GNT_DMA,
    output logic       GNT_REF,
    output logic       SHORT_n,
    output logic       SLOW_n,
    output logic       BRK_n,
    output logic       DONE_CPU,
    output logic       DONE_DMA,
    output logic       DONE_REF,
    output logic       TMOUT,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(DMA_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CYCLE = 2'd1,
        REC   = 2'd2
    } state_t;

    // Handshake: a level request is granted by a GNT held for the whole cycle; the
    // cycle ends with exactly one one-CK pulse, DONE_<owner> on TERM_n or TMOUT on expiry.
    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;      // {ref, dma, cpu}
    logic [2:0]       qual_q, qual_d;    // {short_n, slow_n, brk_n}
    logic [2:0]       done_q, done_d;    // {ref, dma, cpu}
    logic             tmout_q, tmout_d;
    logic [CNT_W-1:0] dma_cnt_q, dma_cnt_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic             cpu_turn;

    // CPU takes precedence over DMA only once a full DMA burst was granted while it waited.
    assign cpu_turn = CPUREQ && (dma_cnt_q == CNT_W'(DMA_BURST));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        qual_d    = qual_q;
        done_d    = 3'b000;
        tmout_d   = 1'b0;
        dma_cnt_d = dma_cnt_q;
        wdog_d    = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (REFREQ) begin
                    state_d = CYCLE;
                    gnt_d   = 3'b100;
                    qual_d  = 3'b011;
                end else if (DMAREQ && !cpu_turn) begin
                    state_d = CYCLE;
                    gnt_d   = 3'b010;
                    qual_d  = 3'b101;
                    if (dma_cnt_q != CNT_W'(DMA_BURST)) begin
                        dma_cnt_d = dma_cnt_q + CNT_W'(1);
                    end
                end else if (CPUREQ) begin
                    state_d   = CYCLE;
                    gnt_d     = 3'b001;
                    qual_d    = {~CPUSHORT, ~(CPUSLOW & ~CPUSHORT), ~CPUBRK};
                    dma_cnt_d = '0;
                end else begin
                    dma_cnt_d = '0;
                end
            end
            CYCLE: begin
                // TERM_n is tested first so a terminate on the expiry edge still completes.
                if (!TERM_n) begin
                    state_d = REC;
                    done_d  = gnt_q;
                    gnt_d   = 3'b000;
                    qual_d  = 3'b111;
                    wdog_d  = '0;
                end else if (wdog_q == TMO_W'(TMO_CYC - 1)) begin
                    state_d = REC;
                    tmout_d = 1'b1;
                    gnt_d   = 3'b000;
                    qual_d  = 3'b111;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + TMO_W'(1);
                end
            end
            REC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                qual_d  = 3'b111;
            end
        endcase
    end

    always_ff @(posedge CK or negedge MR_n) begin
        if (!MR_n) begin
            state_q   <= IDLE;
            gnt_q     <= 3'b000;
            qual_q    <= 3'b111;
            done_q    <= 3'b000;
            tmout_q   <= 1'b0;
            dma_cnt_q <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            qual_q    <= qual_d;
            done_q    <= done_d;
            tmout_q   <= tmout_d;
            dma_cnt_q <= dma_cnt_d;
            wdog_q    <= wdog_d;
        end
    end

    assign GNT_REF   = gnt_q[2];
    assign GNT_DMA   = gnt_q[1];
    assign GNT_CPU   = gnt_q[0];
    assign SHORT_n   = qual_q[2];
    assign SLOW_n    = qual_q[1];
    assign BRK_n     = qual_q[0];
    assign DONE_REF  = done_q[2];
    assign DONE_DMA  = done_q[1];
    assign DONE_CPU  = done_q[0];
    assign TMOUT     = tmout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cyc_arbiter.sv
// Randomized bench for cyc_arbiter: a transaction-level model predicts each grant and
// each completion with its cycle stamp; a negedge monitor pops and compares them.
`timescale 1ns/100ps
module tb_cyc_arbiter;

    localparam int DMA_BURST = 4;
    localparam int TMO_CYC   = 64;

    logic       CK = 1'b0;
    logic       MR_n = 1'b1;
    logic       CPUREQ = 1'b0, CPUSHORT = 1'b0, CPUSLOW = 1'b0, CPUBRK = 1'b0;
    logic       DMAREQ = 1'b0, REFREQ = 1'b0, TERM_n = 1'b1;
    logic       GNT_CPU, GNT_DMA, GNT_REF, SHORT_n, SLOW_n, BRK_n;
    logic       DONE_CPU, DONE_DMA, DONE_REF, TMOUT;
    logic [1:0] dbg_state;

    cyc_arbiter #(.DMA_BURST(DMA_BURST), .TMO_CYC(TMO_CYC), .TMO_W(7)) dut (
        .CK(CK), .MR_n(MR_n), .CPUREQ(CPUREQ), .CPUSHORT(CPUSHORT), .CPUSLOW(CPUSLOW),
        .CPUBRK(CPUBRK), .DMAREQ(DMAREQ), .REFREQ(REFREQ), .TERM_n(TERM_n),
        .GNT_CPU(GNT_CPU), .GNT_DMA(GNT_DMA), .GNT_REF(GNT_REF),
        .SHORT_n(SHORT_n), .SLOW_n(SLOW_n), .BRK_n(BRK_n),
        .DONE_CPU(DONE_CPU), .DONE_DMA(DONE_DMA), .DONE_REF(DONE_REF),
        .TMOUT(TMOUT), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle stamp ----------------
    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [37:0] gnt_q[$];   // {cycle, {ref,dma,cpu}, {short_n,slow_n,brk_n}}
    logic [35:0] end_q[$];   // {cycle, {done_ref,done_dma,done_cpu}, tmout}
    int model_cnt = 0;       // DMA grants in a row while the CPU kept asking

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [2:0] prev_gnt  = 3'b000;
    logic [2:0] prev_qual = 3'b111;

    always @(negedge CK) begin
        logic [2:0]  g;
        logic [2:0]  q;
        logic [3:0]  e;
        logic [37:0] xg;
        logic [35:0] xe;
        g = {GNT_REF, GNT_DMA, GNT_CPU};
        q = {SHORT_n, SLOW_n, BRK_n};
        e = {DONE_REF, DONE_DMA, DONE_CPU, TMOUT};
        check("gnt_onehot", 64'($countones(g) <= 1), 64'd1);
        check("end_onehot", 64'($countones(e) <= 1), 64'd1);
        if (g != 3'b000 && prev_gnt == 3'b000) begin
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got gnt=%b quals=%b, expected no grant (cycle %0d)", g, q, cyc);
            end else begin
                xg = gnt_q.pop_front();
                check("grant", {26'd0, 32'(cyc), g, q}, {26'd0, xg});
            end
        end else if (g != 3'b000) begin
            check("grant_hold", {58'd0, g, q}, {58'd0, prev_gnt, prev_qual});
        end else begin
            check("quals_idle", {61'd0, q}, 64'd7);
        end
        if (e != 4'b0000) begin
            if (end_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_end: got done/tmout=%b, expected none (cycle %0d)", e, cyc);
            end else begin
                xe = end_q.pop_front();
                check("completion", {28'd0, 32'(cyc), e}, {28'd0, xe});
            end
        end
        prev_gnt  = g;
        prev_qual = q;
    end

    // ---------------- driver ----------------
    // Entered #1 after a posedge with the arbiter idle at the next edge. Applies one request
    // pattern, predicts the winner, then ends the cycle on CYCLE edge k (TERM_n low when
    // term=1, otherwise k must be TMO_CYC and the watchdog fires). Returns idle-aligned.
    task automatic run_slot(input logic r, input logic d, input logic c,
                            input logic sh, input logic sl, input logic bk,
                            input int k, input logic term);
        logic [2:0] win;
        logic [2:0] qual;
        REFREQ = r; DMAREQ = d; CPUREQ = c;
        CPUSHORT = sh; CPUSLOW = sl; CPUBRK = bk;
        TERM_n = 1'($urandom_range(0, 1));
        win  = 3'b000;
        qual = 3'b111;
        if (r) begin
            win  = 3'b100;
            qual = 3'b011;
        end else if (d && !(model_cnt == DMA_BURST && c)) begin
            win  = 3'b010;
            qual = 3'b101;
            model_cnt = (model_cnt < DMA_BURST) ? model_cnt + 1 : DMA_BURST;
        end else if (c) begin
            win  = 3'b001;
            qual = {!sh, !(sl && !sh), !bk};
            model_cnt = 0;
        end else begin
            model_cnt = 0;
        end
        if (win == 3'b000) begin
            @(posedge CK); #1;
            return;
        end
        gnt_q.push_back({32'(cyc + 1), win, qual});
        @(posedge CK); #1;
        for (int j = 1; j <= k; j++) begin
            if ($urandom_range(0, 1) == 1) {REFREQ, DMAREQ, CPUREQ} = 3'($urandom);
            TERM_n = !(j == k && term);
            if (j == k) end_q.push_back({32'(cyc + 1), (term ? win : 3'b000), !term});
            @(posedge CK); #1;
        end
        // Recovery cycle: requests and TERM_n here must have no effect.
        {REFREQ, DMAREQ, CPUREQ} = 3'($urandom);
        TERM_n = 1'($urandom_range(0, 1));
        @(posedge CK); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic term;
        #2 MR_n = 1'b0;
        #1;
        check("reset_outputs",
              {54'd0, GNT_CPU, GNT_DMA, GNT_REF, SHORT_n, SLOW_n, BRK_n,
               DONE_CPU, DONE_DMA, DONE_REF, TMOUT},
              {54'd0, 10'b000_111_000_0});
        check("reset_state", 64'(dbg_state), 64'd0);
        @(posedge CK); @(posedge CK); #1;
        MR_n = 1'b1;
        model_cnt = 0;
        @(posedge CK); #1;

        // Basic CPU short cycle: TERM_n high for 3 CK then low.
        run_slot(0, 0, 1, 1, 0, 0, 4, 1);
        // Priority: all three, then DMA+CPU, then CPU alone.
        run_slot(1, 1, 1, 0, 0, 0, 2, 1);
        run_slot(0, 1, 1, 0, 0, 0, 3, 1);
        run_slot(0, 0, 1, 0, 1, 1, 3, 1);
        // Fairness: DMA and CPU both held.
        repeat (10) run_slot(0, 1, 1, 1'($urandom), 1'($urandom), 1'($urandom),
                             $urandom_range(1, 4), 1);
        // Watchdog expiry, then terminate coincident with expiry.
        run_slot(0, 1, 0, 0, 0, 0, TMO_CYC, 0);
        run_slot(0, 0, 1, 0, 0, 0, TMO_CYC, 1);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                k    = TMO_CYC;
                term = 1'($urandom_range(0, 1));
            end else begin
                k    = $urandom_range(1, 8);
                term = 1'b1;
            end
            run_slot($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), k, term);
        end

        // Asynchronous reset in the middle of a CPU break cycle.
        REFREQ = 0; DMAREQ = 0; CPUREQ = 1; CPUSHORT = 0; CPUSLOW = 0; CPUBRK = 1;
        TERM_n = 1;
        gnt_q.push_back({32'(cyc + 1), 3'b001, 3'b110});
        @(posedge CK); #1;
        @(posedge CK); #1;
        MR_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {54'd0, GNT_CPU, GNT_DMA, GNT_REF, SHORT_n, SLOW_n, BRK_n,
               DONE_CPU, DONE_DMA, DONE_REF, TMOUT},
              {54'd0, 10'b000_111_000_0});
        check("async_reset_state", 64'(dbg_state), 64'd0);
        model_cnt = 0;
        CPUREQ = 0; CPUBRK = 0;
        @(posedge CK); #1;
        MR_n = 1'b1;
        repeat (6) begin
            TERM_n = 1'($urandom_range(0, 1));
            @(posedge CK); #1;
        end
        // Burst count restarts from zero after reset: DMA wins over CPU.
        run_slot(0, 1, 1, 0, 0, 0, 2, 1);
        REFREQ = 0; DMAREQ = 0; CPUREQ = 0; TERM_n = 1;
        repeat (4) @(posedge CK);
        #1;

        check("grant_queue_empty", 64'(gnt_q.size()), 64'd0);
        check("end_queue_empty", 64'(end_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
